lfsr_pattern_gen: RTL and testbench

Upstream stimulus source for the 32-bit LFSR sequence checker in the heater/PoC datapath.
- Produces a seeded pseudo-random word stream in which each word is the LFSR next-state of the previous word.
- Uses the same polynomial as the checker.
- Under software control it runs a fixed-length burst or runs continuously.
- It supports a valid/ready handshake, so it can also drive FIFO-buffered paths. A checker fed directly ties ready high.

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_next.sv | 14 +
 rtl/lfsr_pattern_gen.sv | 124 ++++++++++++
 tb/tb_lfsr_pattern_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: width, default seed, feedback taps, FSM states and
// the next-state function used by both the pattern generator and the checker.
package lfsr_pkg;

    localparam int           LFSR_W    = 32;
    localparam logic [31:0]  LFSR_SEED = 32'h0000_0001;
    // Fibonacci taps for x^32 + x^22 + x^2 + x + 1, shifting toward the MSB
    localparam logic [31:0]  LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [LFSR_W-1:0] next_lfsr(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR next-state block; a thin wrapper around next_lfsr so the
// generator and checker always share one polynomial.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int WIDTH = LFSR_W
) (
    input  logic [WIDTH-1:0] cur_i,
    output logic [WIDTH-1:0] nxt_o
);

    assign nxt_o = next_lfsr(cur_i);

endmodule

// File: rtl/lfsr_pattern_gen.sv
// Seeded LFSR word-stream source with burst/continuous modes and valid/ready output.
// Optional single-word bit-0 corruption when LFSR_PATTERN_GEN_ERR_INJECT_EN is defined.
module lfsr_pattern_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = LFSR_W,
    parameter int               CNT_W        = 32,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             start,
    input  logic             stop,
`ifdef LFSR_PATTERN_GEN_ERR_INJECT_EN
    input  logic             inject_err,
`endif
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_count
);

    state_t           state_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] dout_q;
    logic             vld_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;

    logic [WIDTH-1:0] dout_nxt_d;
    logic [WIDTH-1:0] seed_d;
    logic [WIDTH-1:0] start_word_d;
    logic             xfer_d;
    logic             last_word_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    lfsr_next #(.WIDTH(WIDTH)) u_next (
        .cur_i (dout_q),
        .nxt_o (dout_nxt_d)
    );

    // A zero seed would lock the LFSR up, so it is replaced by the default.
    assign seed_d       = (seed == '0) ? DEFAULT_SEED : seed;
    assign start_word_d = seed_load ? seed_d : lfsr_q;
    assign xfer_d       = vld_q & dout_ready;
    assign last_word_d  = (len_q != '0) && (cnt_q == len_q - CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= DEFAULT_SEED;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        len_q   <= burst_len;
                        cnt_q   <= '0;
                        dout_q  <= start_word_d;
                        lfsr_q  <= start_word_d;
                        vld_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        if (seed_load) lfsr_q <= seed_d;
                    end
                end
                RUN: begin
                    // stop wins over a same-cycle transfer; lfsr_q keeps the unsent word
                    if (stop) begin
                        state_q <= IDLE;
                        vld_q   <= 1'b0;
                    end else if (xfer_d) begin
                        dout_q <= dout_nxt_d;
                        lfsr_q <= dout_nxt_d;
                        cnt_q  <= sat_inc(cnt_q);
                        if (last_word_d) begin
                            state_q <= DONE;
                            vld_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LFSR_PATTERN_GEN_ERR_INJECT_EN
    logic err_arm_q;
    logic xfer_ok_d;

    assign xfer_ok_d = (state_q == RUN) && !stop && xfer_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_arm_q <= 1'b0;
        else       err_arm_q <= (err_arm_q & ~xfer_ok_d) | inject_err;
    end

    assign dout = dout_q ^ {{(WIDTH-1){1'b0}}, err_arm_q & vld_q};
`else
    assign dout = dout_q;
`endif

    assign dout_valid = vld_q;
    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Directed bench for lfsr_pattern_gen: bursts, zero seed, ready throttling,
// continuous mode with stop, and asynchronous reset mid-burst.
module tb_lfsr_pattern_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        seed_load = 1'b0;
    logic [31:0] seed = '0;
    logic [31:0] burst_len = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        inject_err = 1'b0;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] word_count;

    int total = 0;
    int bad = 0;

    // Hand-derived sequence from seed 1 with taps 31,21,1,0
    logic [31:0] W [0:10] = '{32'h001, 32'h003, 32'h006, 32'h00D, 32'h01B, 32'h036,
                              32'h06D, 32'h0DB, 32'h1B6, 32'h36D, 32'h6DB};

    lfsr_pattern_gen dut (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed       (seed),
        .burst_len  (burst_len),
        .start      (start),
        .stop       (stop),
`ifdef LFSR_PATTERN_GEN_ERR_INJECT_EN
        .inject_err (inject_err),
`endif
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int xf;
        logic seen_done;

        #1 reset = 1'b1;
        tick();
        tick();
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wc", word_count, 0);
        reset = 1'b0;
        tick();

        // Burst of 4 from seed 1
        seed_load = 1; seed = 32'h1; burst_len = 4; start = 1; dout_ready = 1;
        tick();
        seed_load = 0; start = 0;
        check("b4_busy", busy, 1);
        for (int k = 0; k < 4; k++) begin
            check("b4_valid", dout_valid, 1);
            check("b4_word", dout, W[k]);
            check("b4_nodone", done, 0);
            tick();
        end
        check("b4_valid_end", dout_valid, 0);
        check("b4_done", done, 1);
        check("b4_wc", word_count, 4);
        check("b4_busy_end", busy, 0);
        tick();
        check("b4_done_once", done, 0);

        // Next burst continues seamlessly from next(word 4)
        burst_len = 2; start = 1;
        tick();
        start = 0;
        check("cont_w0", dout, W[4]);
        tick();
        check("cont_w1", dout, W[5]);
        tick();
        check("cont_done", done, 1);
        check("cont_wc", word_count, 2);
        tick();

        // Zero seed falls back to the default; ready toggled 1010...
        seed_load = 1; seed = 32'h0; burst_len = 8; start = 1; dout_ready = 0;
        tick();
        seed_load = 0; start = 0;
        check("z_first", dout, W[0]);
        xf = 0;
        seen_done = 0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            dout_ready = (i % 2 == 0);
            if (dout_valid) check("tog_word", dout, W[xf]);
            if (dout_valid && dout_ready) xf++;
            tick();
            if (done) seen_done = 1;
        end
        check("tog_seen_done", seen_done, 1);
        check("tog_xfers", xf, 8);
        check("tog_wc", word_count, 8);
        dout_ready = 1;
        tick();

        // Continuous mode; seed_load/start in RUN ignored; stop beats transfer
        seed_load = 1; seed = 32'h1; burst_len = 0; start = 1;
        tick();
        seed_load = 0; start = 0;
        tick();
        seed_load = 1; seed = 32'h1234; start = 1; burst_len = 2;
        tick();
        seed_load = 0; start = 0; burst_len = 0;
        tick();
        check("run_ign_word", dout, W[3]);
        check("run_ign_wc", word_count, 3);
        check("run_busy", busy, 1);
        stop = 1;
        tick();
        stop = 0;
        check("stop_valid", dout_valid, 0);
        check("stop_busy", busy, 0);
        check("stop_wc", word_count, 3);
        check("stop_nodone", done, 0);
        burst_len = 1; start = 1;
        tick();
        start = 0;
        check("stop_resume", dout, W[3]);
        tick();
        check("b1_done", done, 1);
        check("b1_wc", word_count, 1);
        tick();

        // 1000-cycle continuous run, stop on cycle 1000 with ready high
        seed_load = 1; seed = 32'h1; burst_len = 0; start = 1;
        tick();
        seed_load = 0; start = 0;
        seen_done = 0;
        repeat (999) begin
            tick();
            if (done) seen_done = 1;
        end
        check("long_wc", word_count, 999);
        check("long_valid", dout_valid, 1);
        stop = 1;
        tick();
        stop = 0;
        check("long_stop_wc", word_count, 999);
        check("long_stop_busy", busy, 0);
        check("long_stop_valid", dout_valid, 0);
        tick();
        if (done) seen_done = 1;
        check("long_nodone", seen_done, 0);

        // Asynchronous reset between edges mid-burst
        seed_load = 1; seed = 32'h55; burst_len = 10; start = 1;
        tick();
        seed_load = 0; start = 0;
        tick();
        #3 reset = 1'b1;
        #1;
        check("arst_valid", dout_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_dout", dout, 0);
        tick();
        reset = 1'b0;
        burst_len = 2; start = 1;
        tick();
        start = 0;
        check("arst_resume", dout, W[0]);
        tick();
        check("arst_w1", dout, W[1]);
        tick();
        check("arst_done2", done, 1);
        check("arst_wc", word_count, 2);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
